// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder for the controller's
// rd/wr/data_e strobes. A programmable number of wait states is inserted
// between acceptance and response. Read data is registered, completion is a
// one-cycle ready pulse, and illegal strobe combinations raise a one-cycle
// err pulse. A backdoor port writes the array directly in any state.
module mem_responder #(
  parameter int AWIDTH      = 5,
  parameter int DWIDTH      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  input  logic              data_e,
  input  logic [DWIDTH-1:0] data_in,
  output logic [DWIDTH-1:0] data_out,
  output logic              ready,
  output logic              busy,
  output logic              err,
  input  logic              bd_we,
  input  logic [AWIDTH-1:0] bd_addr,
  input  logic [DWIDTH-1:0] bd_data
);

  localparam int DEPTH = 2 ** AWIDTH;
  // Wait-state count as loaded into the 4-bit counter (legal range 0..15).
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic [3:0]        cnt;
  logic [3:0]        cnt_nxt;
  logic              busy_nxt;
  logic              ready_nxt;
  logic              err_nxt;

  // Transaction context captured at acceptance.
  logic              is_wr_q;
  logic [AWIDTH-1:0] addr_q;
  logic [DWIDTH-1:0] data_q;

  // Decoded actions for the current cycle.
  logic              accept;
  logic              accept_wr;
  logic              rd_commit;
  logic              wr_commit;
  logic              strobe_held;

  logic [DWIDTH-1:0] mem [DEPTH];

  // The strobe that started the transaction must stay high through WAIT.
  assign strobe_held = is_wr_q ? wr : rd;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode, next values of the registered outputs, and commit strobes.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    ready_nxt = 1'b0;
    err_nxt   = 1'b0;
    accept    = 1'b0;
    accept_wr = 1'b0;
    rd_commit = 1'b0;
    wr_commit = 1'b0;

    case (state)
      S_IDLE: begin
        if (rd && wr) begin
          // Both strobes together is never a legal request.
          err_nxt = 1'b1;
        end else if (rd) begin
          accept = 1'b1;
        end else if (wr && data_e) begin
          accept    = 1'b1;
          accept_wr = 1'b1;
        end else if (wr) begin
          // Write without data enable: flag it, do not accept.
          err_nxt = 1'b1;
        end

        if (accept) begin
          busy_nxt  = 1'b1;
          cnt_nxt   = WAIT_INIT;
          state_nxt = (WAIT_INIT == 4'd0) ? S_RESP : S_WAIT;
        end
      end

      S_WAIT: begin
        if (!strobe_held) begin
          // Initiator withdrew the request: drop it silently.
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
          cnt_nxt   = 4'd0;
        end else if (cnt <= 4'd1) begin
          state_nxt = S_RESP;
          cnt_nxt   = 4'd0;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end

      S_RESP: begin
        ready_nxt = 1'b1;
        rd_commit = ~is_wr_q;
        wr_commit = is_wr_q;
        state_nxt = S_HOLD;
      end

      S_HOLD: begin
        // Hold off until the initiator releases every strobe, so a strobe
        // still held after ready cannot start a second transaction.
        if (!rd && !wr) begin
          state_nxt = S_IDLE;
          busy_nxt  = 1'b0;
        end
      end

      default: begin
        state_nxt = S_IDLE;
        busy_nxt  = 1'b0;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Control registers: wait counter, status pulses and transaction direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= 4'd0;
      busy    <= 1'b0;
      ready   <= 1'b0;
      err     <= 1'b0;
      is_wr_q <= 1'b0;
    end else begin
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      ready <= ready_nxt;
      err   <= err_nxt;
      if (accept) begin
        is_wr_q <= accept_wr;
      end
    end
  end

  // Address and write data are captured once at acceptance; later changes on
  // the bus are ignored for the rest of the transaction.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q <= addr;
    end
    if (accept_wr) begin
      data_q <= data_in;
    end
  end

  // Registered read data; holds its value between reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (rd_commit) begin
      data_out <= mem[addr_q];
    end
  end

  // Storage array. The bus write is placed after the backdoor write so that
  // it takes priority when both target the same word in the same cycle.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      mem[bd_addr] <= bd_data;
    end
    if (wr_commit) begin
      mem[addr_q] <= data_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: three instances (0, 1 and 4 wait states) share one
// stimulus stream and are checked cycle by cycle against a transaction-level
// model holding one memory image and one read-data register per instance.
module tb_mem_responder;

  localparam int AW   = 5;
  localparam int DW   = 8;
  localparam int NDUT = 3;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic          data_e;
  logic [DW-1:0] data_in;
  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;

  logic [DW-1:0] dout [NDUT];
  logic          rdy  [NDUT];
  logic          bsy  [NDUT];
  logic          er   [NDUT];

  int n_checks;
  int n_errors;

  logic [DW-1:0] mem_m   [NDUT][2**AW];
  logic [DW-1:0] last_do [NDUT];

  mem_responder #(.AWIDTH(AW), .DWIDTH(DW), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd), .wr(wr), .data_e(data_e),
    .data_in(data_in), .data_out(dout[0]), .ready(rdy[0]), .busy(bsy[0]),
    .err(er[0]), .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data));

  mem_responder #(.AWIDTH(AW), .DWIDTH(DW), .WAIT_CYCLES(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd), .wr(wr), .data_e(data_e),
    .data_in(data_in), .data_out(dout[1]), .ready(rdy[1]), .busy(bsy[1]),
    .err(er[1]), .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data));

  mem_responder #(.AWIDTH(AW), .DWIDTH(DW), .WAIT_CYCLES(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .rd(rd), .wr(wr), .data_e(data_e),
    .data_in(data_in), .data_out(dout[2]), .ready(rdy[2]), .busy(bsy[2]),
    .err(er[2]), .bd_we(bd_we), .bd_addr(bd_addr), .bd_data(bd_data));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic int wc(input int i);
    return (i == 0) ? 0 : ((i == 1) ? 1 : 4);
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Compare every instance's outputs against the given expectations.
  task automatic check_all(input string tag, input int k, input logic [NDUT-1:0] rdy_e,
                           input logic [NDUT-1:0] bsy_e, input logic [NDUT-1:0] err_e);
    for (int i = 0; i < NDUT; i++) begin
      check_eq($sformatf("%s w%0d k%0d ready", tag, wc(i), k), {31'd0, rdy[i]}, {31'd0, rdy_e[i]});
      check_eq($sformatf("%s w%0d k%0d busy", tag, wc(i), k), {31'd0, bsy[i]}, {31'd0, bsy_e[i]});
      check_eq($sformatf("%s w%0d k%0d err", tag, wc(i), k), {31'd0, er[i]}, {31'd0, err_e[i]});
      check_eq($sformatf("%s w%0d k%0d data_out", tag, wc(i), k), {24'd0, dout[i]}, {24'd0, last_do[i]});
    end
  endtask

  // Backdoor write of one word (all instances). Starts and ends at a negedge.
  task automatic bd_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk);
    for (int i = 0; i < NDUT; i++) mem_m[i][a] = d;
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // One transaction: strobe held for h edges starting at edge 0, optional
  // backdoor write at edge bd_k. Outcome per instance with w wait states:
  // completes iff h >= w+1; ready after edge w+1; busy until edge max(w+2,h)
  // on completion, until edge h on abort.
  task automatic run_txn(input bit is_wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input int h, input int bd_k, input logic [AW-1:0] bda,
                         input logic [DW-1:0] bdd);
    int kmax;
    int w;
    bit comp;
    logic [NDUT-1:0] rdy_e;
    logic [NDUT-1:0] bsy_e;
    kmax = imax(h, 6);
    addr = a; data_in = d; rd = ~is_wr; wr = is_wr;
    data_e = is_wr ? 1'b1 : 1'($urandom_range(0, 1));
    bd_we = (bd_k == 0); bd_addr = bda; bd_data = bdd;
    for (int k = 0; k <= kmax; k++) begin
      @(posedge clk);
      for (int i = 0; i < NDUT; i++) begin
        w = wc(i);
        comp = (h >= w + 1);
        if (comp && k == w + 1 && !is_wr) last_do[i] = mem_m[i][a];
        if (bd_k == k) mem_m[i][bda] = bdd;
        if (comp && k == w + 1 && is_wr) mem_m[i][a] = d;
        rdy_e[i] = comp && (k == w + 1);
        bsy_e[i] = comp ? (k < imax(w + 2, h)) : (k < h);
      end
      #1;
      check_all(is_wr ? "wr" : "rd", k, rdy_e, bsy_e, '0);
      @(negedge clk);
      if (k == 0) begin
        addr = AW'($urandom);
        data_in = DW'($urandom);
      end
      if (k == h - 1) begin
        rd = 1'b0; wr = 1'b0;
      end
      bd_we = (bd_k == k + 1);
    end
    bd_we = 1'b0;
  endtask

  // Illegal strobes for n cycles while idle: err every cycle, nothing accepted.
  task automatic run_err(input int n, input bit both);
    rd = both; wr = 1'b1;
    data_e = both ? 1'($urandom_range(0, 1)) : 1'b0;
    addr = AW'($urandom); data_in = DW'($urandom);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      check_all(both ? "err_rdwr" : "err_noDE", k, '0, '0, '1);
      @(negedge clk);
    end
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    check_all("err_clear", n, '0, '0, '0);
    @(negedge clk);
  endtask

  task automatic run_idle(input int n);
    for (int k = 0; k < n; k++) begin
      addr = AW'($urandom); data_in = DW'($urandom); data_e = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_all("idle", k, '0, '0, '0);
      @(negedge clk);
    end
  endtask

  // Write accepted at edge 0, asynchronous reset after edge 1. Only an
  // instance whose response edge (w+1) has already passed commits the data.
  task automatic run_reset_mid(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a; data_in = d; wr = 1'b1; data_e = 1'b1; rd = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    for (int i = 0; i < NDUT; i++) if (wc(i) + 1 <= 1) mem_m[i][a] = d;
    #3;
    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) last_do[i] = '0;
    #1;
    check_all("async_rst", 0, '0, '0, '0);
    @(negedge clk);
    wr = 1'b0; data_e = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("post_rst", 1, '0, '0, '0);
    @(negedge clk);
  endtask

  initial begin
    logic [AW-1:0] ra;
    logic [AW-1:0] rba;
    int rbk;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b1; addr = '0; rd = 1'b0; wr = 1'b0; data_e = 1'b0; data_in = '0;
    bd_we = 1'b0; bd_addr = '0; bd_data = '0;
    for (int i = 0; i < NDUT; i++) last_do[i] = '0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all("reset", 0, '0, '0, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Preload the whole array through the backdoor.
    for (int a = 0; a < 2**AW; a++) bd_write(AW'(a), DW'($urandom));

    // Directed read, including a long-held strobe.
    bd_write(5'd5, 8'hA7);
    run_txn(1'b0, 5'd5, 8'h00, 3, -1, '0, '0);
    run_txn(1'b0, 5'd5, 8'h00, 5, -1, '0, '0);

    // Write to the top address, then read it back.
    run_txn(1'b1, 5'd31, 8'h3C, 6, -1, '0, '0);
    run_txn(1'b0, 5'd31, 8'h00, 6, -1, '0, '0);

    // Protocol errors, then confirm memory untouched.
    run_err(2, 1'b0);
    run_err(1, 1'b1);
    run_txn(1'b0, 5'd31, 8'h00, 6, -1, '0, '0);

    // Abort: strobe dropped during the wait states of the slow instance.
    bd_write(5'd2, 8'h11);
    run_txn(1'b1, 5'd2, 8'h55, 2, -1, '0, '0);
    run_idle(1);
    run_txn(1'b0, 5'd2, 8'h00, 6, -1, '0, '0);

    // Backdoor collisions with a bus write and with a bus read.
    run_txn(1'b1, 5'd7, 8'h99, 6, 2, 5'd7, 8'h44);
    run_txn(1'b0, 5'd7, 8'h00, 6, -1, '0, '0);
    run_txn(1'b0, 5'd7, 8'h00, 6, 2, 5'd7, 8'h66);
    run_txn(1'b0, 5'd7, 8'h00, 6, -1, '0, '0);

    // Reset in the middle of a write, then a normal read.
    run_reset_mid(5'd9, 8'hE1);
    run_txn(1'b0, 5'd9, 8'h00, 6, -1, '0, '0);

    // Randomized traffic, back to back or with gaps and error bursts.
    for (int t = 0; t < 60; t++) begin
      ra = AW'($urandom);
      rbk = -1;
      rba = '0;
      if ($urandom_range(0, 3) == 0) begin
        rbk = int'($urandom_range(0, 6));
        rba = ($urandom_range(0, 1) == 0) ? ra : AW'($urandom);
      end
      run_txn(1'($urandom_range(0, 1)), ra, DW'($urandom), int'($urandom_range(1, 7)),
              rbk, rba, DW'($urandom));
      if ($urandom_range(0, 5) == 0) run_err(int'($urandom_range(1, 2)), 1'($urandom_range(0, 1)));
      run_idle(int'($urandom_range(0, 1)));
    end

    // Final sweep: read every address back on all instances.
    for (int a = 0; a < 2**AW; a++) run_txn(1'b0, AW'(a), 8'h00, 1, -1, '0, '0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU controller's bus strobes (rd, wr, data_e).
- Accepts one read or write transaction at a time and inserts a programmable number of wait states.
- Returns a registered read data word with a one-cycle ready pulse, and flags protocol errors.
- Sits between the controller/address mux and the datapath's data bus; replaces the zero-latency behavioural memory in the lab top level.

Parameters:
- AWIDTH, 5, address width; memory depth is 2**AWIDTH words.
- DWIDTH, 8, data word width.
- WAIT_CYCLES, 1, wait states inserted per access; legal range 0..15.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- addr  input  AWIDTH  transaction address, sampled at acceptance.
- rd  input  1  read strobe, level; held by the initiator until ready is seen.
- wr  input  1  write strobe, level; held by the initiator until ready is seen.
- data_e  input  1  write data enable; must be high with wr.
- data_in  input  DWIDTH  write data, sampled at acceptance.
- data_out  output  DWIDTH  read data, registered; holds its last value.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high from acceptance until return to IDLE.
- err  output  1  one-cycle protocol-error pulse.
- bd_we  input  1  backdoor write enable, for preload and bench use.
- bd_addr  input  AWIDTH  backdoor address.
- bd_data  input  DWIDTH  backdoor data.

Behaviour:
- Reset (rst_n low, asynchronous): state goes to IDLE; data_out=0, ready=0, busy=0, err=0; wait counter=0.
  - Memory array is not reset.
  - A transaction in flight is dropped with no write committed.
- States: IDLE, WAIT, RESP, HOLD. All outputs are registered.
- IDLE, evaluated at each rising edge:
  - rd=1, wr=0: accept the read. Latch addr; busy<=1; counter<=WAIT_CYCLES. Go to WAIT, or to RESP if WAIT_CYCLES=0.
  - wr=1, rd=0, data_e=1: accept the write. Latch addr and data_in; rest as for a read.
  - wr=1, data_e=0: err<=1 for one cycle; no acceptance; stay in IDLE.
  - rd=1 and wr=1 together: err<=1 for one cycle; no acceptance; stay in IDLE.
  - An error pulse re-fires every cycle the illegal condition persists.
- WAIT: counter decrements each cycle; move to RESP when the counter reaches 1.
  - If the accepted strobe drops during WAIT: abort. Go to IDLE, busy<=0, no ready, no write, no err.
- RESP (exactly one cycle):
  - Read: data_out<=mem[addr_q]; ready<=1.
  - Write: mem[addr_q]<=data_q; ready<=1.
  - Then go to HOLD.
- HOLD: wait for both rd and wr low, then go to IDLE and set busy<=0.
  - This prevents a held strobe from re-triggering.
  - ready is low in HOLD.
- Latency: acceptance edge E0; ready is high in the cycle after edge E0+WAIT_CYCLES+1. data_out is valid in that same cycle.
- Minimum transaction period is WAIT_CYCLES+3 cycles: accept, wait states, RESP, HOLD exit.
- Backdoor:
  - bd_we writes mem[bd_addr]<=bd_data on the rising edge, in any state.
  - If bd_we and a RESP write hit the same address in the same cycle, the bus write wins.
  - A RESP read of an address being backdoor-written that cycle returns the old contents.
- Addresses wrap naturally at 2**AWIDTH; there is no out-of-range check.
- data_in and addr changes after acceptance are ignored.

Test Plan:
- Read with WAIT_CYCLES=1: backdoor mem[5]=8'hA7; assert rd with addr=5 at E0 -> busy high from E0; ready high for exactly 1 cycle after E0+2 with data_out=8'hA7; busy drops after rd is released.
- Write then read back: wr=1, data_e=1, addr=31, data_in=8'h3C -> ready pulse after WAIT_CYCLES+1 edges; a following read of addr=31 returns 8'h3C. Changing data_in after acceptance has no effect.
- Protocol errors: wr=1, data_e=0 for 2 cycles -> err high 2 cycles, no busy, memory unchanged. rd=wr=1 -> err pulse, no acceptance.
- Abort: WAIT_CYCLES=4; start a write to addr 2 (old value 8'h11) and drop wr during WAIT -> no ready, busy low next cycle, mem[2] still 8'h11.
- Reset mid-operation: rst_n low during WAIT of a write -> outputs 0 immediately (asynchronous), state IDLE after release, mem unchanged; a new read completes normally.
- WAIT_CYCLES=0 with rd held 5 cycles: ready is a single pulse one cycle after acceptance; no second transaction until rd goes low; back-to-back reads are WAIT_CYCLES+3 cycles apart.
